// File: rtl/game_ctrl.sv
// Flappy-style game controller: button debounce, LFSR, bird/pipe physics.
// All game outputs are registered and advance once per frame_tick.
module game_ctrl #(
   parameter int SCREEN_H   = 480,
   parameter int BIRD_H     = 24,
   parameter int BIRD_X     = 160,
   parameter int BIRD_Y0    = 228,
   parameter int GRAVITY    = 1,
   parameter int FLAP_VEL   = -8,
   parameter int VEL_MAX    = 8,
   parameter int PIPE_X0    = 640,
   parameter int PIPE_SPEED = 2,
   parameter int GAP_MIN    = 80,
   parameter int DB_CYCLES  = 250000
) (
   input  logic       pix_clk,
   input  logic       pix_rstn,
   input  logic       button,
   input  logic       frame_tick,
   input  logic       collide,
   output logic [1:0] state,
   output logic [9:0] bird_y,
   output logic [9:0] pipe_x,
   output logic [9:0] gap_y,
   output logic [7:0] score
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      DEAD = 2'd2,
      BAD  = 2'd3
   } state_t;

   localparam int CW = $clog2(DB_CYCLES + 1);
   localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);
   localparam logic [9:0] Y0  = 10'(BIRD_Y0);
   localparam logic [9:0] X0  = 10'(PIPE_X0);
   localparam logic [9:0] BX  = 10'(BIRD_X);
   localparam logic [9:0] SPD = 10'(PIPE_SPEED);
   localparam logic [9:0] GMN = 10'(GAP_MIN);
   localparam logic signed [11:0] YLIM = 12'(SCREEN_H - BIRD_H);
   localparam logic signed [8:0]  VMAX = 9'(VEL_MAX);
   localparam logic signed [8:0]  GRV  = 9'(GRAVITY);
   localparam logic signed [7:0]  FV   = 8'(FLAP_VEL);

   state_t cur, nxt;
   logic signed [7:0] vel, v_n;
   logic [9:0] y_n, px_n, g_n;
   logic [7:0] s_n;

   logic s1, s2, db, flap, rise;
   logic [CW-1:0] cnt;
   logic [15:0] lfsr;
   logic fb;

   logic signed [11:0] ny;
   logic signed [8:0]  vinc;
   logic signed [7:0]  vcl;
   logic [9:0] px_play, g_play;
   logic wrap, pass, hit;

   assign state = cur;
   assign fb    = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
   assign rise  = s2 & ~db & (cnt == DB_LAST);

   assign ny      = {2'b00, bird_y} + {{4{vel[7]}}, vel};
   assign vinc    = {vel[7], vel} + GRV;
   assign vcl     = (vinc > VMAX) ? VMAX[7:0] : vinc[7:0];
   assign wrap    = (pipe_x <= SPD);
   assign px_play = wrap ? X0 : pipe_x - SPD;
   assign g_play  = wrap ? GMN + {2'b00, lfsr[7:0]} : gap_y;
   assign pass    = (pipe_x > BX) && (px_play <= BX);
   assign hit     = collide || ny[11] || (ny > YLIM);

   // synchronizer, debounce, sticky flap request and free-running LFSR
   always_ff @(posedge pix_clk) begin
      if (!pix_rstn) begin
         s1   <= 1'b0;
         s2   <= 1'b0;
         db   <= 1'b0;
         cnt  <= '0;
         flap <= 1'b0;
         lfsr <= 16'hACE1;
      end else begin
         s1   <= button;
         s2   <= s1;
         lfsr <= {lfsr[14:0], fb};
         if (s2 != db) begin
            if (cnt == DB_LAST) begin
               db  <= s2;
               cnt <= '0;
            end else begin
               cnt <= cnt + CW'(1);
            end
         end else begin
            cnt <= '0;
         end
         if (rise)
            flap <= 1'b1;
         else if (frame_tick)
            flap <= 1'b0;
      end
   end

   // game state and registered outputs
   always_ff @(posedge pix_clk) begin
      if (!pix_rstn) begin
         cur    <= IDLE;
         bird_y <= Y0;
         vel    <= '0;
         pipe_x <= X0;
         gap_y  <= GMN + 10'h0E1;
         score  <= '0;
      end else begin
         cur    <= nxt;
         bird_y <= y_n;
         vel    <= v_n;
         pipe_x <= px_n;
         gap_y  <= g_n;
         score  <= s_n;
      end
   end

   // next-state and per-frame physics
   always_comb begin
      nxt  = cur;
      y_n  = bird_y;
      v_n  = vel;
      px_n = pipe_x;
      g_n  = gap_y;
      s_n  = score;
      unique case (cur)
         IDLE: begin
            if (frame_tick && flap) begin
               nxt = PLAY;
               v_n = FV;
            end
         end
         PLAY: begin
            if (frame_tick) begin
               if (hit) begin
                  nxt = DEAD;
               end else begin
                  y_n  = ny[9:0];
                  v_n  = flap ? FV : vcl;
                  px_n = px_play;
                  g_n  = g_play;
                  if (pass && score != 8'hFF)
                     s_n = score + 8'd1;
               end
            end
         end
         DEAD: begin
            if (frame_tick && flap) begin
               nxt  = IDLE;
               y_n  = Y0;
               v_n  = '0;
               px_n = X0;
               s_n  = '0;
            end
         end
         default: nxt = IDLE;
      endcase
   end

endmodule
